// File: rtl/ultra_pkg.sv
// Shared types and default timing for the ultrasonic ranger and its Avalon front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ultra_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  localparam int DIST_W = 16;

  // Defaults for a 50 MHz clock.
  localparam int TRIG_CYCLES_DEF      = 500;
  localparam int CLKS_PER_CM_DEF      = 2900;
  localparam int MAX_CM_DEF           = 400;
  localparam int ECHO_WAIT_CYCLES_DEF = 50000;
  localparam int STUCK_CM_DEF         = 500;
  localparam int HOLDOFF_CYCLES_DEF   = 3000000;
  localparam int CAR_NEAR_CM_DEF      = 30;
  localparam int CAR_FAR_CM_DEF       = 40;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ultra_echo_sync.sv
// Two-flop synchronizer for the raw echo line with registered rise/fall pulses.
// Latency: rise/fall pulse is high in the cycle after the 3rd edge following the raw change.
// Backpressure: none; pulses are single-cycle and not held.
// Ports: clk, reset (sync, active-high), echo (async raw input),
//        rise/fall (one-cycle pulses on synchronized edges).
module ultra_echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;   // previous value of stage 2, for edge detection
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    s1_d   = echo;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/ultra_sonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing, cm conversion, fault and car flags.
// Latency: data_valid rises 3 cycles after the first edge that samples echo low.
// Backpressure: none; distance/data_valid are fire-and-forget, enable only gates new pings in IDLE.
// Ports: clk, reset (sync, active-high), enable, echo (raw async) in;
//        trigger, distance[15:0], data_valid, broken, busy, car out.
// Optional: `define ULTRA_CAR_DETECT_EN builds the car-present hysteresis; otherwise car is tied 0.
module ultra_sonic_ranger
  import ultra_pkg::*;
#(
  parameter int TRIG_CYCLES      = TRIG_CYCLES_DEF,
  parameter int CLKS_PER_CM      = CLKS_PER_CM_DEF,
  parameter int MAX_CM           = MAX_CM_DEF,
  parameter int ECHO_WAIT_CYCLES = ECHO_WAIT_CYCLES_DEF,
  parameter int STUCK_CM         = STUCK_CM_DEF,
`ifdef ULTRA_CAR_DETECT_EN
  parameter int CAR_NEAR_CM      = CAR_NEAR_CM_DEF,
  parameter int CAR_FAR_CM       = CAR_FAR_CM_DEF,
`endif
  parameter int HOLDOFF_CYCLES   = HOLDOFF_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              echo,
  output logic              trigger,
  output logic [DIST_W-1:0] distance,
  output logic              data_valid,
  output logic              broken,
  output logic              busy,
  output logic              car
);

  localparam int CNT_MAX = max_int(max_int(TRIG_CYCLES, ECHO_WAIT_CYCLES), HOLDOFF_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SUB_W   = (CLKS_PER_CM > 1) ? $clog2(CLKS_PER_CM) : 1;

  localparam logic [CNT_W-1:0]  TRIG_LIM  = CNT_W'(TRIG_CYCLES);
  localparam logic [CNT_W-1:0]  ECHO_LIM  = CNT_W'(ECHO_WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  HOLD_LIM  = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CLKS_PER_CM - 1);
  localparam logic [DIST_W-1:0] MAX_LIM   = DIST_W'(MAX_CM);
  localparam logic [DIST_W-1:0] STUCK_LIM = DIST_W'(STUCK_CM);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              trig_q, trig_d;
  logic              dv_q, dv_d;
  logic              broken_q, broken_d;

  logic              echo_rise, echo_fall;
  logic [CNT_W-1:0]  cnt_inc;
  logic              sub_wrap;
  logic [DIST_W-1:0] cm_inc;

  ultra_echo_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .echo  (echo),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    cm_d     = cm_q;
    dist_d   = dist_q;
    trig_d   = 1'b0;
    dv_d     = 1'b0;
    broken_d = broken_q;

    cnt_inc  = cnt_q + CNT_W'(1);
    sub_wrap = (sub_q == SUB_LAST);
    // cm count including this cycle, so the final echo cycle is not lost on the fall edge
    cm_inc   = cm_q + DIST_W'(sub_wrap);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          trig_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        trig_d = 1'b1;
        cnt_d  = cnt_inc;
        if (cnt_inc == TRIG_LIM) begin
          trig_d  = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d = MEASURE;
          cnt_d   = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == ECHO_LIM) begin
            broken_d = 1'b1;
            cnt_d    = '0;
            state_d  = HOLDOFF;
          end
        end
      end
      MEASURE: begin
        sub_d = sub_wrap ? '0 : sub_q + SUB_W'(1);
        cm_d  = cm_inc;
        // a fall on the same cycle as the stuck limit still counts as a good echo
        if (echo_fall) begin
          dist_d   = (cm_inc > MAX_LIM) ? MAX_LIM : cm_inc;
          dv_d     = 1'b1;
          broken_d = 1'b0;
          cnt_d    = '0;
          state_d  = HOLDOFF;
        end else if (cm_inc >= STUCK_LIM) begin
          broken_d = 1'b1;
          cnt_d    = '0;
          state_d  = HOLDOFF;
        end
      end
      HOLDOFF: begin
        cnt_d = cnt_inc;
        if (cnt_inc == HOLD_LIM) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sub_q    <= '0;
      cm_q     <= '0;
      dist_q   <= '0;
      trig_q   <= 1'b0;
      dv_q     <= 1'b0;
      broken_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      cm_q     <= cm_d;
      dist_q   <= dist_d;
      trig_q   <= trig_d;
      dv_q     <= dv_d;
      broken_q <= broken_d;
    end
  end

  assign trigger    = trig_q;
  assign distance   = dist_q;
  assign data_valid = dv_q;
  assign broken     = broken_q;
  assign busy       = (state_q != IDLE);

`ifdef ULTRA_CAR_DETECT_EN
  // Hysteresis: two consecutive good samples on one side of the band flip the flag.
  logic [1:0] near_q, near_d;
  logic [1:0] far_q, far_d;
  logic       car_q, car_d;

  always_comb begin
    near_d = near_q;
    far_d  = far_q;
    car_d  = car_q;
    if (dv_d) begin
      if (dist_d < DIST_W'(CAR_NEAR_CM)) begin
        far_d  = 2'd0;
        near_d = (near_q == 2'd2) ? 2'd2 : near_q + 2'd1;
        if (near_d == 2'd2) car_d = 1'b1;
      end else if (dist_d > DIST_W'(CAR_FAR_CM)) begin
        near_d = 2'd0;
        far_d  = (far_q == 2'd2) ? 2'd2 : far_q + 2'd1;
        if (far_d == 2'd2) car_d = 1'b0;
      end else begin
        near_d = 2'd0;
        far_d  = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      near_q <= 2'd0;
      far_q  <= 2'd0;
      car_q  <= 1'b0;
    end else begin
      near_q <= near_d;
      far_q  <= far_d;
      car_q  <= car_d;
    end
  end

  assign car = car_q;
`else
  assign car = 1'b0;
`endif

endmodule

// File: tb/tb_ultra_sonic_ranger.sv
module tb_ultra_sonic_ranger;

  localparam int TRIG = 5;
  localparam int CPC  = 4;
  localparam int EW   = 20;
  localparam int HO   = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   sel = 0;
  logic e_drv = 1'b0;
  logic en_drv = 1'b0;

  logic enable, echo, trigger, data_valid, broken, busy, car;
  logic enable_s, echo_s, trigger_s, data_valid_s, broken_s, busy_s, car_s;
  logic [15:0] distance, distance_s;

  logic m_trig, m_dv, m_broken, m_busy, m_car;
  logic [15:0] m_dist;

  always #5 clk = ~clk;

  assign enable   = (sel == 0) ? en_drv : 1'b0;
  assign echo     = (sel == 0) ? e_drv  : 1'b0;
  assign enable_s = (sel == 1) ? en_drv : 1'b0;
  assign echo_s   = (sel == 1) ? e_drv  : 1'b0;

  assign m_trig   = (sel == 1) ? trigger_s    : trigger;
  assign m_dv     = (sel == 1) ? data_valid_s : data_valid;
  assign m_broken = (sel == 1) ? broken_s     : broken;
  assign m_busy   = (sel == 1) ? busy_s       : busy;
  assign m_car    = (sel == 1) ? car_s        : car;
  assign m_dist   = (sel == 1) ? distance_s   : distance;

  ultra_sonic_ranger #(
    .TRIG_CYCLES(TRIG), .CLKS_PER_CM(CPC), .MAX_CM(400),
    .ECHO_WAIT_CYCLES(EW), .STUCK_CM(500), .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trigger(trigger),
    .distance(distance), .data_valid(data_valid), .broken(broken), .busy(busy), .car(car)
  );

  ultra_sonic_ranger #(
    .TRIG_CYCLES(TRIG), .CLKS_PER_CM(CPC), .MAX_CM(8),
    .ECHO_WAIT_CYCLES(EW), .STUCK_CM(12), .HOLDOFF_CYCLES(HO)
  ) dut_sat (
    .clk(clk), .reset(reset), .enable(enable_s), .echo(echo_s), .trigger(trigger_s),
    .distance(distance_s), .data_valid(data_valid_s), .broken(broken_s), .busy(busy_s), .car(car_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, one slot per instance.
  int maxc[2]  = '{400, 8};
  int stuck[2] = '{500, 12};
  int md[2];
  bit mb[2];
  bit mc[2];
  int hist[2][$];

  int dvc[2];
  int trc[2];
  logic trig_prev0 = 1'b0, trig_prev1 = 1'b0;

  always @(negedge clk) begin
    if (data_valid)   dvc[0]++;
    if (data_valid_s) dvc[1]++;
    if (trigger && !trig_prev0)   trc[0]++;
    if (trigger_s && !trig_prev1) trc[1]++;
    trig_prev0 = trigger;
    trig_prev1 = trigger_s;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit exp_car(input int s);
`ifdef ULTRA_CAR_DETECT_EN
    return mc[s];
`else
    return 1'b0;
`endif
  endfunction

  // Car flag: the last two good distances both below near, or both above far.
  function automatic void model_good(input int s, input int d);
    md[s] = d;
    mb[s] = 1'b0;
    hist[s].push_back(d);
    if (hist[s].size() > 2) void'(hist[s].pop_front());
    if (hist[s].size() == 2) begin
      if (hist[s][0] < 30 && hist[s][1] < 30) mc[s] = 1'b1;
      if (hist[s][0] > 40 && hist[s][1] > 40) mc[s] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      md[s] = 0;
      mb[s] = 1'b0;
      mc[s] = 1'b0;
      hist[s].delete();
    end
  endfunction

  task automatic wait_idle();
    int b = 0;
    while (m_busy && b < 300) begin
      b++;
      @(negedge clk);
    end
    chk("busy_idle", m_busy, 0);
  endtask

  // One complete ping: len==0 means the echo never rises.
  task automatic ping(input int dly, input int len, input bit drop_mid);
    bit got = 0;
    bit early = 0;
    int tw = 0;
    int b = 0;
    int dv0;
    int good;
    en_drv = 1'b1;
    e_drv  = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = m_trig;
    end
    chk("trigger_start", got, 1);
    if (!got) return;
    if (!drop_mid) en_drv = 1'b0;
    while (m_trig && tw < 50) begin
      tw++;
      @(negedge clk);
    end
    chk("trigger_width", tw, TRIG);
    dv0 = dvc[sel];
    good = 0;
    if (len == 0) begin
      repeat (EW - 1) @(negedge clk);
      chk("pre_timeout_broken", m_broken, mb[sel]);
      @(negedge clk);
      chk("timeout_broken", m_broken, 1);
      mb[sel] = 1'b1;
    end else begin
      repeat (dly) @(negedge clk);
      e_drv = 1'b1;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if (drop_mid && i == len / 2) en_drv = 1'b0;
      end
      e_drv = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (m_dv) early = 1'b1;
      end
      chk("dv_early", early, 0);
      @(negedge clk);
      if (len <= stuck[sel] * CPC) begin
        good = 1;
        model_good(sel, (len / CPC > maxc[sel]) ? maxc[sel] : len / CPC);
        chk("dv_at_3", m_dv, 1);
        chk("dist_at_dv", m_dist, md[sel]);
        chk("broken_at_dv", m_broken, 0);
        chk("car_at_dv", m_car, exp_car(sel));
        while (m_busy && b < 100) begin
          b++;
          @(negedge clk);
        end
        chk("holdoff_len", b, HO);
      end else begin
        chk("stuck_no_dv", m_dv, 0);
        mb[sel] = 1'b1;
      end
    end
    wait_idle();
    chk("dv_count", dvc[sel] - dv0, good);
    chk("distance", m_dist, md[sel]);
    chk("broken", m_broken, mb[sel]);
    chk("car", m_car, exp_car(sel));
    en_drv = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_trigger"}, trigger, 0);
    chk({tag, "_distance"}, distance, 0);
    chk({tag, "_dv"}, data_valid, 0);
    chk({tag, "_broken"}, broken, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_car"}, car, 0);
  endtask

  typedef struct {
    int dly;
    int len;
    int exp_dist;
    bit exp_broken;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tr0, dv0;
    tbl.push_back('{2, 42, 10, 0});
    tbl.push_back('{3,  0, 10, 1});
    tbl.push_back('{1, 44, 11, 0});
    tbl.push_back('{2, 200, 50, 0});
    tbl.push_back('{2, 80, 20, 0});
    tbl.push_back('{1, 80, 20, 0});
    tbl.push_back('{1, 140, 35, 0});
    tbl.push_back('{3, 180, 45, 0});
    tbl.push_back('{2, 180, 45, 0});
    tbl.push_back('{2,  3,  0, 0});
    tbl.push_back('{4,  4,  1, 0});
    tbl.push_back('{1,  7,  1, 0});

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    sel = 0;
    foreach (tbl[i]) begin
      ping(tbl[i].dly, tbl[i].len, 1'b0);
      chk("tbl_distance", distance, tbl[i].exp_dist);
      chk("tbl_broken", broken, tbl[i].exp_broken);
`ifdef ULTRA_CAR_DETECT_EN
      if (i == 5) chk("car_rise_3rd", car, 1);
      if (i == 8) chk("car_fall_6th", car, 0);
`endif
    end

    for (int r = 0; r < 8; r++) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 160));
      ping(int'($urandom_range(1, 6)), len, 1'b0);
    end

    // Saturation and stuck echo on the small-limit instance.
    sel = 1;
    ping(2, 40, 1'b0);
    chk("sat_distance", distance_s, 8);
    ping(2, 60, 1'b0);
    chk("stuck_broken", broken_s, 1);
    chk("stuck_distance", distance_s, 8);
    ping(2, 20, 1'b0);
    chk("sat_recover_broken", broken_s, 0);

    // enable dropped while measuring: strobe still comes, no new ping afterwards.
    sel = 0;
    ping(2, 30, 1'b1);
    tr0 = trc[0];
    repeat (30) @(negedge clk);
    chk("no_retrigger", trc[0] - tr0, 0);
    chk("parked_idle", busy, 0);

    // Reset in the middle of TRIG.
    dv0 = dvc[0];
    en_drv = 1'b1;
    for (int k = 0; k < 20 && !trigger; k++) @(negedge clk);
    en_drv = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_trig_active", trigger, 1);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_reset_vals("rst_trig");
    reset = 1'b0;

    // Reset in the middle of MEASURE.
    en_drv = 1'b1;
    for (int k = 0; k < 20 && !trigger; k++) @(negedge clk);
    en_drv = 1'b0;
    for (int k = 0; k < 20 && trigger; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    e_drv = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_meas");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    e_drv = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_strobe", dvc[0] - dv0, 0);
    chk("rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
